unsigned_complete_divider: RTL and testbench

Sequential unsigned restoring divider: the inverse companion of the shift-add unsigned multiplier, using the same level-held `run` / `rdy` handshake. The block contains its own control FSM and datapath. It takes a WIDTH-bit dividend and divisor and produces quotient and remainder after WIDTH iterations, one iteration per clock. It sits beside the multiplier in the arithmetic unit and serves divide instructions.

---
 rtl/unsigned_complete_divider.sv | 140 ++++++++++++++
 tb/tb_unsigned_complete_divider.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/unsigned_complete_divider.sv
// Sequential unsigned restoring divider.
// Produces one quotient bit per clock and finishes after WIDTH iterations.
// Uses a level-held run / rdy handshake. A zero divisor completes in one cycle
// and raises div_by_zero.
module unsigned_complete_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             rdy,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [CW-1:0]      count_q, count_d;
    logic               rdy_q, rdy_d;
    logic               busy_q, busy_d;
    logic               dbz_q, dbz_d;

    // Trial subtraction: the top WIDTH+1 bits of R against the divisor.
    // The extra MSB of t exposes the borrow.
    logic [WIDTH:0]     p;
    logic [WIDTH+1:0]   t;
    logic [2*WIDTH-1:0] r_step;
    logic               unused_t_msb;

    assign p = r_q[2*WIDTH-1:WIDTH-1];
    assign t = {1'b0, p} - {2'b00, d_q};

    // While the upper half stays below D, t[WIDTH] is zero whenever no borrow occurs.
    assign unused_t_msb = t[WIDTH];

    // One restoring step.
    // No borrow: keep the difference and shift in a 1.
    // Borrow: shift R left and shift in a 0.
    assign r_step = t[WIDTH+1] ? {r_q[2*WIDTH-2:0], 1'b0}
                               : {t[WIDTH-1:0], r_q[WIDTH-2:0], 1'b1};

    // Next-state and next-output logic for the control FSM and datapath.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        d_d     = d_q;
        count_d = count_q;
        rdy_d   = rdy_q;
        busy_d  = busy_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (run) begin
                    if (divisor != '0) begin
                        r_d     = {{WIDTH{1'b0}}, dividend};
                        d_d     = divisor;
                        count_d = '0;
                        busy_d  = 1'b1;
                        state_d = ITER;
                    end else begin
                        // Divide by zero: remainder = dividend, quotient = all ones.
                        r_d     = {dividend, {WIDTH{1'b1}}};
                        dbz_d   = 1'b1;
                        rdy_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            ITER: begin
                if (!run) begin
                    // Abort: R and D keep their partial values.
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    r_d     = r_step;
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) begin
                        busy_d  = 1'b0;
                        rdy_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!run) begin
                    rdy_d   = 1'b0;
                    dbz_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                rdy_d   = 1'b0;
                busy_d  = 1'b0;
                dbz_d   = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            d_q     <= '0;
            count_q <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            d_q     <= d_d;
            count_q <= count_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = r_q[WIDTH-1:0];
    assign remainder   = r_q[2*WIDTH-1:WIDTH];
    assign rdy         = rdy_q;
    assign busy        = busy_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_unsigned_complete_divider.sv
// Self-checking bench for unsigned_complete_divider (WIDTH = 32).
// A behavioural model derives the results with / and %, and the handshake
// from the cycle-count rules. Directed cases pin known literal answers.
module tb_unsigned_complete_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         run = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient, remainder;
    logic         rdy, busy, div_by_zero;

    int checks = 0;
    int failures = 0;

    unsigned_complete_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .rdy         (rdy),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model.
    // m_phase: 0 = waiting, 1 = dividing, 2 = holding a result.
    // m_known: quotient and remainder have a defined expected value.
    int           m_phase = 0;
    int           m_cnt = 0;
    logic         m_rdy = 1'b0;
    logic         m_busy = 1'b0;
    logic         m_dbz = 1'b0;
    logic         m_known = 1'b1;
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_r = '0;
    logic [W-1:0] m_eq = '0;
    logic [W-1:0] m_er = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_rdy   <= 1'b0;
            m_busy  <= 1'b0;
            m_dbz   <= 1'b0;
            m_known <= 1'b1;
            m_q     <= '0;
            m_r     <= '0;
        end else begin
            case (m_phase)
                0: if (run) begin
                    if (divisor == 0) begin
                        m_q     <= '1;
                        m_r     <= dividend;
                        m_rdy   <= 1'b1;
                        m_dbz   <= 1'b1;
                        m_known <= 1'b1;
                        m_phase <= 2;
                    end else begin
                        m_eq    <= dividend / divisor;
                        m_er    <= dividend % divisor;
                        m_cnt   <= 0;
                        m_busy  <= 1'b1;
                        m_known <= 1'b0;
                        m_phase <= 1;
                    end
                end
                1: if (!run) begin
                    m_busy  <= 1'b0;
                    m_phase <= 0;
                end else begin
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == W - 1) begin
                        m_busy  <= 1'b0;
                        m_rdy   <= 1'b1;
                        m_q     <= m_eq;
                        m_r     <= m_er;
                        m_known <= 1'b1;
                        m_phase <= 2;
                    end
                end
                default: if (!run) begin
                    m_rdy   <= 1'b0;
                    m_dbz   <= 1'b0;
                    m_phase <= 0;
                end
            endcase
        end
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        chk("rdy", {63'd0, rdy}, {63'd0, m_rdy});
        chk("busy", {63'd0, busy}, {63'd0, m_busy});
        chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, m_dbz});
        if (busy && rdy)
            chk("busy_and_rdy", 64'd1, 64'd0);
        if (m_known) begin
            chk("quotient", {32'd0, quotient}, {32'd0, m_q});
            chk("remainder", {32'd0, remainder}, {32'd0, m_r});
        end
    end

    // Run one operation.
    // lat is the index of the edge after which rdy is first seen (load edge = 1).
    // With scr set, the operands change to sd/sv right after the load edge.
    task automatic do_op(input logic [W-1:0] dd, input logic [W-1:0] dv,
                         input bit scr, input logic [W-1:0] sd, input logic [W-1:0] sv,
                         output int lat, output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z);
        int  k;
        bit  got;
        k = 0;
        got = 0;
        run = 1'b1;
        dividend = dd;
        divisor = dv;
        while (!got && k < 60) begin
            @(posedge clk);
            k++;
            #2;
            if (k == 1 && scr) begin
                dividend = sd;
                divisor = sv;
            end
            @(negedge clk);
            if (rdy) got = 1;
        end
        lat = k;
        q = quotient;
        r = remainder;
        z = div_by_zero;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL rdy_timeout: rdy not seen within %0d edges for %0d/%0d", k, dd, dv);
        end
        $display("op %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d", dd, dv, q, r, z, lat);
        @(posedge clk);
        #2;
        run = 1'b0;
        @(posedge clk);
        #2;
        @(negedge clk);
        chk("rdy_after_drop", {63'd0, rdy}, 64'd0);
        chk("dbz_after_drop", {63'd0, div_by_zero}, 64'd0);
    endtask

    initial begin
        int           lat;
        logic [W-1:0] q, r, a, b;
        logic         z;
        bit           seen;

        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_quotient", {32'd0, quotient}, 64'd0);
        chk("reset_remainder", {32'd0, remainder}, 64'd0);
        chk("reset_rdy", {63'd0, rdy}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_dbz", {63'd0, div_by_zero}, 64'd0);

        // 100 / 7
        do_op(32'd100, 32'd7, 1'b0, 32'd0, 32'd0, lat, q, r, z);
        chk("lat_100_7", 64'(lat), 64'd33);
        chk("q_100_7", {32'd0, q}, 64'd14);
        chk("r_100_7", {32'd0, r}, 64'd2);
        chk("z_100_7", {63'd0, z}, 64'd0);

        // Large operands
        do_op(32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 32'd0, lat, q, r, z);
        chk("q_max_1", {32'd0, q}, 64'hFFFFFFFF);
        chk("r_max_1", {32'd0, r}, 64'd0);
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd0, lat, q, r, z);
        chk("q_max_max", {32'd0, q}, 64'd1);
        chk("r_max_max", {32'd0, r}, 64'd0);
        do_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd0, lat, q, r, z);
        chk("q_msb_max", {32'd0, q}, 64'd0);
        chk("r_msb_max", {32'd0, r}, 64'h80000000);

        // Dividend smaller than divisor
        do_op(32'd3, 32'd10, 1'b0, 32'd0, 32'd0, lat, q, r, z);
        chk("q_3_10", {32'd0, q}, 64'd0);
        chk("r_3_10", {32'd0, r}, 64'd3);

        // Divide by zero
        do_op(32'd5, 32'd0, 1'b0, 32'd0, 32'd0, lat, q, r, z);
        chk("lat_5_0", 64'(lat), 64'd1);
        chk("q_5_0", {32'd0, q}, 64'hFFFFFFFF);
        chk("r_5_0", {32'd0, r}, 64'd5);
        chk("z_5_0", {63'd0, z}, 64'd1);

        // Abort 1000 / 33 at cycle 10, then restart with operands changed after load
        run = 1'b1;
        dividend = 32'd1000;
        divisor = 32'd33;
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #2;
            if (rdy) seen = 1;
        end
        run = 1'b0;
        @(posedge clk);
        #2;
        if (rdy) seen = 1;
        @(negedge clk);
        chk("abort_rdy_never", {63'd0, seen}, 64'd0);
        chk("abort_busy_low", {63'd0, busy}, 64'd0);
        do_op(32'd1000, 32'd33, 1'b1, 32'd77, 32'd77, lat, q, r, z);
        chk("lat_restart", 64'(lat), 64'd33);
        chk("q_1000_33", {32'd0, q}, 64'd30);
        chk("r_1000_33", {32'd0, r}, 64'd10);

        // Reset in the middle of an iteration
        run = 1'b1;
        dividend = 32'd123456;
        divisor = 32'd789;
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_quotient", {32'd0, quotient}, 64'd0);
        chk("rst_mid_remainder", {32'd0, remainder}, 64'd0);
        chk("rst_mid_rdy", {63'd0, rdy}, 64'd0);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        do_op(32'd123456, 32'd789, 1'b0, 32'd0, 32'd0, lat, q, r, z);
        chk("lat_after_rst", 64'(lat), 64'd33);
        chk("q_after_rst", {32'd0, q}, 64'd156);
        chk("r_after_rst", {32'd0, r}, 64'd372);

        // Randomized operations with operand changes after the load edge
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = a + 32'($urandom_range(1, 100));
                3: b = $urandom | 32'h80000000;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            do_op(a, b, 1'b1, $urandom, $urandom, lat, q, r, z);
            chk("lat_random", 64'(lat), (b == 0) ? 64'd1 : 64'd33);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
